// File: rtl/sram_bist_pkg.sv
// Shared types, pass tables and the march pattern for the SRAM self-test master.
// Types and the pattern function here are common to the default build and the SRAM_BIST_TIMEOUT_EN build.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } bist_state_t;

  typedef logic [1:0] pass_idx_t;

  localparam int        PASS_CNT  = 4;
  localparam pass_idx_t LAST_PASS = 2'(PASS_CNT - 1);

  // Bit p describes pass p: passes 1 and 3 verify, passes 2 and 3 use the inverted pattern.
  localparam logic [PASS_CNT-1:0] PASS_IS_READ = 4'b1010;
  localparam logic [PASS_CNT-1:0] PASS_INVERT  = 4'b1100;

  localparam int PAT_W = 64;

  // Callers zero-extend address and seed to PAT_W and truncate the result to DATA_W,
  // which gives seed XOR A(a) with A(a) zero-extended or truncated as the widths require.
  function automatic logic [PAT_W-1:0] bist_pattern(input logic [PAT_W-1:0] addr,
                                                    input logic [PAT_W-1:0] seed,
                                                    input logic             inv);
    logic [PAT_W-1:0] p;
    p = seed ^ addr;
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// Avalon-MM bus bundle shared by the BIST master (initiator) and the SRAM controller (target).
// Identical in the default build and the SRAM_BIST_TIMEOUT_EN build.
interface avalon_mm_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  modport initiator (
    output address, read, write, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport target (
    input  address, read, write, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/sram_bist_checker.sv
// Read-data compare for the BIST: saturating mismatch counter and first-failing-address capture.
// Identical in the default build and the SRAM_BIST_TIMEOUT_EN build.
module sram_bist_checker
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 16,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 check_en,
  input  logic [DATA_W-1:0]    rdata,
  input  logic [DATA_W-1:0]    expected,
  input  logic [ADDR_W-1:0]    addr,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [ADDR_W-1:0]    first_err_addr
);

  logic mismatch_s;

  assign mismatch_s = check_en && (rdata != expected);

  // Error statistics: cleared by an accepted start, updated on each mismatching read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= {ERR_CNT_W{1'b0}};
      first_err_addr <= {ADDR_W{1'b0}};
    end else if (clear) begin
      err_cnt        <= {ERR_CNT_W{1'b0}};
      first_err_addr <= {ADDR_W{1'b0}};
    end else if (mismatch_s) begin
      if (err_cnt != {ERR_CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
      if (err_cnt == {ERR_CNT_W{1'b0}}) begin
        first_err_addr <= addr;
      end
    end
  end

endmodule

// File: rtl/sram_bist_master.sv
// Avalon-MM BIST initiator: write P, verify P, write ~P, verify ~P over addresses 0..last_addr.
// Optional read watchdog enabled by defining SRAM_BIST_TIMEOUT_EN; otherwise timeout_o is tied 0.
module sram_bist_master
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int ERR_CNT_W     = 16
`ifdef SRAM_BIST_TIMEOUT_EN
  ,
  parameter int TIMEOUT_TICKS = 64
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  avalon_mm_if.initiator       mem_if,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    last_addr_i,
  input  logic [DATA_W-1:0]    seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [ADDR_W-1:0]    first_err_addr_o,
  output logic                 timeout_o
);

  bist_state_t       state_r;
  pass_idx_t         pass_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] last_addr_r;
  logic [DATA_W-1:0] seed_r;

  logic [ADDR_W-1:0] nxt_addr_s;
  pass_idx_t         nxt_pass_s;
  logic              nxt_is_rd_s;
  logic [DATA_W-1:0] nxt_data_s;
  logic [DATA_W-1:0] exp_data_s;
  logic              clear_s;
  logic              check_en_s;
  logic              last_txn_s;

`ifdef SRAM_BIST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);
  logic [WD_W-1:0] wdog_r;
  logic            timeout_r;
  assign timeout_o = timeout_r;
`else
  assign timeout_o = 1'b0;
`endif

  assign clear_s     = (state_r == IDLE) && start_i;
  assign check_en_s  = (state_r == RD_WAIT) && mem_if.readdatavalid;
  assign last_txn_s  = (addr_r == last_addr_r) && (pass_r == LAST_PASS);
  assign nxt_is_rd_s = PASS_IS_READ[nxt_pass_s];
  assign nxt_data_s  = DATA_W'(bist_pattern(PAT_W'(nxt_addr_s), PAT_W'(seed_r), PASS_INVERT[nxt_pass_s]));
  assign exp_data_s  = DATA_W'(bist_pattern(PAT_W'(addr_r), PAT_W'(seed_r), PASS_INVERT[pass_r]));

  // Address/pass that follow the current transaction; compare precedes increment so all-ones cannot overflow.
  always_comb begin
    nxt_addr_s = {ADDR_W{1'b0}};
    nxt_pass_s = pass_r;
    if (addr_r == last_addr_r) begin
      nxt_addr_s = {ADDR_W{1'b0}};
      nxt_pass_s = pass_r + 2'd1;
    end else begin
      nxt_addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      nxt_pass_s = pass_r;
    end
  end

  // Test sequencer with registered bus command and status outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r          <= IDLE;
      pass_r           <= 2'd0;
      addr_r           <= {ADDR_W{1'b0}};
      last_addr_r      <= {ADDR_W{1'b0}};
      seed_r           <= {DATA_W{1'b0}};
      mem_if.address   <= {ADDR_W{1'b0}};
      mem_if.writedata <= {DATA_W{1'b0}};
      mem_if.read      <= 1'b0;
      mem_if.write     <= 1'b0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
`ifdef SRAM_BIST_TIMEOUT_EN
      wdog_r           <= {WD_W{1'b0}};
      timeout_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            last_addr_r      <= last_addr_i;
            seed_r           <= seed_i;
            addr_r           <= {ADDR_W{1'b0}};
            pass_r           <= 2'd0;
            mem_if.address   <= {ADDR_W{1'b0}};
            mem_if.writedata <= seed_i;
            mem_if.write     <= 1'b1;
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
`ifdef SRAM_BIST_TIMEOUT_EN
            timeout_r        <= 1'b0;
`endif
            state_r          <= WR_REQ;
          end
        end
        WR_REQ: begin
          if (!mem_if.waitrequest) begin
            mem_if.write <= 1'b0;
            state_r      <= NEXT;
          end
        end
        RD_REQ: begin
          if (!mem_if.waitrequest) begin
            mem_if.read <= 1'b0;
`ifdef SRAM_BIST_TIMEOUT_EN
            wdog_r      <= {WD_W{1'b0}};
`endif
            state_r     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_if.readdatavalid) begin
            state_r <= NEXT;
          end
`ifdef SRAM_BIST_TIMEOUT_EN
          else if (wdog_r == WD_W'(TIMEOUT_TICKS - 1)) begin
            timeout_r <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            pass_o    <= 1'b0;
            state_r   <= DONE;
          end else begin
            wdog_r <= wdog_r + WD_W'(1);
          end
`endif
        end
        NEXT: begin
          if (last_txn_s) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            pass_o  <= (err_cnt_o == {ERR_CNT_W{1'b0}}) && !timeout_o;
            state_r <= DONE;
          end else begin
            addr_r           <= nxt_addr_s;
            pass_r           <= nxt_pass_s;
            mem_if.address   <= nxt_addr_s;
            mem_if.writedata <= nxt_data_s;
            mem_if.read      <= nxt_is_rd_s;
            mem_if.write     <= !nxt_is_rd_s;
            state_r          <= nxt_is_rd_s ? RD_REQ : WR_REQ;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  sram_bist_checker #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ERR_CNT_W (ERR_CNT_W)
  ) u_checker (
    .clk            (clk_i),
    .rst_n          (rst_n_i),
    .clear          (clear_s),
    .check_en       (check_en_s),
    .rdata          (mem_if.readdata),
    .expected       (exp_data_s),
    .addr           (addr_r),
    .err_cnt        (err_cnt_o),
    .first_err_addr (first_err_addr_o)
  );

endmodule

// File: tb/tb_sram_bist_master.sv
// Self-checking bench for sram_bist_master: SRAM responder with stalls and stuck-at faults,
// table-driven directed runs, randomized runs against a reference model, mid-test reset and the watchdog.
module tb_sram_bist_master;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int ERR_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] seed = '0;
  logic              busy, done, pass_f, timeout;
  logic [ERR_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_err;

  avalon_mm_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_CNT_W(ERR_W)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .mem_if           (bus),
    .start_i          (start),
    .last_addr_i      (last_addr),
    .seed_i           (seed),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass_f),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err),
    .timeout_o        (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- SRAM responder model ----------------
  typedef struct { bit is_wr; int addr; logic [15:0] data; } txn_t;
  txn_t        txn_q[$];
  logic [15:0] mem [int];
  int          faddr = -1;      // -1 no fault, -2 every address, else one address
  int          fbit = 0;
  int          stall_cfg = 0;
  bit          rand_stall = 0;
  bit          no_resp = 0;
  int          first_rd_cyc = -1;

  initial begin
    logic [15:0]       w;
    logic [15:0]       rd_val;
    txn_t              acc_t;
    bit                acc_pend, counting, prev_stalled, p_rd, p_wr;
    logic [ADDR_W-1:0] p_addr;
    logic [15:0]       p_data;
    int                stall_left, rd_cnt;
    acc_pend = 0; counting = 0; prev_stalled = 0; stall_left = 0; rd_cnt = 0; rd_val = '0;
    p_rd = 0; p_wr = 0; p_addr = '0; p_data = '0;
    bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        acc_pend = 0; counting = 0; prev_stalled = 0; rd_cnt = 0;
        bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0;
      end else begin
        if (acc_pend) begin
          txn_q.push_back(acc_t);
          if (acc_t.is_wr) begin
            w = acc_t.data;
            if (faddr == -2 || faddr == acc_t.addr) w[fbit] = 1'b0;
            mem[acc_t.addr] = w;
          end else begin
            rd_val = mem.exists(acc_t.addr) ? mem[acc_t.addr] : 16'h0000;
            rd_cnt = rand_stall ? $urandom_range(3, 1) : 1;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
          end
        end
        bus.readdatavalid = 1'b0;
        if (rd_cnt > 0 && !no_resp) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            bus.readdatavalid = 1'b1;
            bus.readdata = rd_val;
          end
        end
        if (prev_stalled)
          check("stall_hold", {bus.read, bus.write, bus.address, bus.writedata}, {p_rd, p_wr, p_addr, p_data});
        acc_pend = 0; prev_stalled = 0; bus.waitrequest = 1'b0;
        if (bus.read || bus.write) begin
          if (!counting) begin
            counting = 1;
            stall_left = rand_stall ? $urandom_range(2, 0) : stall_cfg;
          end
          if (stall_left > 0) begin
            stall_left--;
            bus.waitrequest = 1'b1;
            prev_stalled = 1;
            p_rd = bus.read; p_wr = bus.write; p_addr = bus.address; p_data = bus.writedata;
          end else begin
            counting = 0;
            acc_pend = 1;
            acc_t = '{bus.write, int'(bus.address), bus.writedata};
          end
        end else begin
          counting = 0;
        end
      end
    end
  end

  // Reference: errors a read pass would see given what the faulty memory stores.
  function automatic void ref_result(input int la, input logic [15:0] sd, input int fa, input int fb,
                                     output int e_err, output int e_first);
    logic [15:0] want, got;
    e_err = 0; e_first = 0;
    for (int p = 1; p < 4; p += 2)
      for (int a = 0; a <= la; a++) begin
        want = sd ^ 16'(a);
        if (p == 3) want = ~want;
        got = want;
        if (fa == -2 || fa == a) got[fb] = 1'b0;
        if (got != want) begin
          if (e_err == 0) e_first = a;
          e_err++;
        end
      end
    if (e_err > 15) e_err = 15;
  endfunction

  task automatic run_case(input int la, input logic [15:0] sd, input int fa, input int fb, input int st,
                          input bit rs, input bit mid, input int e_err, input int e_first, input bit e_pass);
    bit          hit;
    int          idx;
    logic [15:0] exp_d;
    txn_q.delete(); mem.delete();
    faddr = fa; fbit = fb; stall_cfg = st; rand_stall = rs; first_rd_cyc = -1;
    @(posedge clk); #1;
    last_addr = ADDR_W'(la); seed = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; last_addr = ADDR_W'($urandom_range(40, 0)); seed = 16'($urandom);
    hit = 0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(posedge clk); #2;
      if (i == 0) check("busy_run", busy, 1);
      if (mid && i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      if (done) hit = 1;
    end
    start = 1'b0;
    check("done", hit, 1);
    check("pass", pass_f, e_pass);
    check("err_cnt", err_cnt, e_err);
    check("first_err", first_err, e_first);
    check("timeout", timeout, 0);
    check("busy_end", busy, 0);
    @(posedge clk); #2;
    check("done_hold", done, 1);
    check("txn_count", txn_q.size(), 4 * (la + 1));
    idx = 0;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a <= la; a++) begin
        if (idx < txn_q.size()) begin
          exp_d = sd ^ 16'(a);
          if (p >= 2) exp_d = ~exp_d;
          check("txn_op", txn_q[idx].is_wr, (p % 2 == 0));
          check("txn_addr", txn_q[idx].addr, a);
          if (p % 2 == 0) check("txn_data", txn_q[idx].data, exp_d);
        end
        idx++;
      end
  endtask

  typedef struct { int la; logic [15:0] sd; int fa; int fb; int st; bit mid; int e_err; int e_first; bit e_pass; } vec_t;
  vec_t tbl[6];

  initial begin
    int          e_err, e_first, la, fa, fb;
    logic [15:0] sd;
    bit          hit;
    tbl[0] = '{15, 16'hA5A5, -1, 0, 0, 0,  0, 0, 1};
    tbl[1] = '{15, 16'h0000,  5, 3, 0, 0,  1, 5, 0};
    tbl[2] = '{15, 16'hA5A5, -1, 0, 3, 1,  0, 0, 1};
    tbl[3] = '{ 0, 16'h1234, -1, 0, 3, 1,  0, 0, 1};
    tbl[4] = '{15, 16'h0000, -2, 3, 0, 0, 15, 8, 0};
    tbl[5] = '{ 3, 16'hFFFF,  2, 0, 1, 0,  1, 2, 0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read", bus.read, 0);
    check("rst_write", bus.write, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_f, 0);
    check("rst_err", err_cnt, 0);
    check("rst_first", first_err, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_case(tbl[i].la, tbl[i].sd, tbl[i].fa, tbl[i].fb, tbl[i].st, 0, tbl[i].mid,
               tbl[i].e_err, tbl[i].e_first, tbl[i].e_pass);

    for (int r = 0; r < 8; r++) begin
      la = $urandom_range(20, 0);
      sd = 16'($urandom);
      case ($urandom_range(2, 0))
        0: fa = -1;
        1: fa = $urandom_range(la, 0);
        default: fa = -2;
      endcase
      fb = $urandom_range(15, 0);
      ref_result(la, sd, fa, fb, e_err, e_first);
      run_case(la, sd, fa, fb, 0, 1, 0, e_err, e_first, (e_err == 0));
    end

    // Reset in the middle of the last verify pass, with errors already counted.
    txn_q.delete(); mem.delete();
    faddr = -2; fbit = 3; stall_cfg = 0; rand_stall = 0;
    @(posedge clk); #1;
    last_addr = ADDR_W'(15); seed = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(posedge clk); #2;
      if (txn_q.size() >= 50 && bus.read) hit = 1;
    end
    check("reset_reach", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_read", bus.read, 0);
    check("mrst_write", bus.write, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_pass", pass_f, 0);
    check("mrst_err", err_cnt, 0);
    check("mrst_first", first_err, 0);
    check("mrst_timeout", timeout, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_case(15, 16'hA5A5, -1, 0, 0, 0, 0, 0, 0, 1);

`ifdef SRAM_BIST_TIMEOUT_EN
    txn_q.delete(); mem.delete();
    faddr = -1; stall_cfg = 0; rand_stall = 0; no_resp = 1; first_rd_cyc = -1;
    @(posedge clk); #1;
    last_addr = ADDR_W'(3); seed = 16'h0F0F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #2;
      if (timeout) hit = 1;
    end
    check("to_seen", hit, 1);
    check("to_latency", cyc - first_rd_cyc, 64);
    check("to_done", done, 1);
    check("to_pass", pass_f, 0);
    check("to_busy", busy, 0);
    no_resp = 0;
    repeat (4) @(posedge clk);
    #2;
    check("to_hold", timeout, 1);
    check("to_late_err", err_cnt, 0);
    check("to_late_done", done, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
